// File: rtl/gray_seq_pkg.sv
// Shared types, default parameters and Gray conversion helpers for the
// gray_seq_ctrl display sequencer.
package gray_seq_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DIV   = 50_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  // Both helpers work on a 32-bit zero-extended value; callers truncate.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Link between the sequencer FSM and its prescaler: the controller enables
// and clears the divider, the divider returns a one-cycle tick.
interface gray_seq_ctrl_if;
  logic en;
  logic clr;
  logic tick;

  modport master (output en, output clr, input tick);
  modport slave  (input en, input clr, output tick);
endinterface

// File: rtl/gray_seq_tick.sv
// DIV-cycle prescaler with enable and synchronous clear; tick marks the
// last cycle of each DIV-cycle period while enabled.
module gray_seq_tick #(
  parameter int unsigned DIV = gray_seq_pkg::DEF_DIV
) (
  input  logic          clk,
  input  logic          rst_n,
  gray_seq_ctrl_if.slave tk
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          term;

  assign term    = (cnt_q == TERM);
  assign tk.tick = tk.en && term;

  always_comb begin
    cnt_d = cnt_q;
    if (tk.clr || !tk.en || term) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Binary counter sequencer feeding the Gray LED display: run/step/direction
// and parallel load. Define GRAY_SEQ_CHECK_EN to build the Gray consistency checker.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_sw,
  input  logic             dir_sw,
  input  logic             load_sw,
  input  logic             step_n,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrap_o,
  output logic [1:0]       state_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAXV = '1;

  // Two-flop synchronizers; load and step keep one extra flop for edge detect.
  logic run_m_q, run_s_q, dir_m_q, dir_s_q;
  logic load_m_q, load_s_q, load_l_q;
  logic step_m_q, step_s_q, step_l_q;
  logic load_p, step_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_m_q  <= 1'b0;
      run_s_q  <= 1'b0;
      dir_m_q  <= 1'b0;
      dir_s_q  <= 1'b0;
      load_m_q <= 1'b0;
      load_s_q <= 1'b0;
      load_l_q <= 1'b0;
      step_m_q <= 1'b1;
      step_s_q <= 1'b1;
      step_l_q <= 1'b1;
    end else begin
      run_m_q  <= run_sw;
      run_s_q  <= run_m_q;
      dir_m_q  <= dir_sw;
      dir_s_q  <= dir_m_q;
      load_m_q <= load_sw;
      load_s_q <= load_m_q;
      load_l_q <= load_s_q;
      step_m_q <= step_n;
      step_s_q <= step_m_q;
      step_l_q <= step_s_q;
    end
  end

  assign load_p = load_s_q & ~load_l_q;
  assign step_p = ~step_s_q & step_l_q;

  gray_seq_ctrl_if tk_if ();

  gray_seq_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tk    (tk_if.slave)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             advance;

  // Prescaler runs only while RUN is held; a load restarts the period.
  assign tk_if.en  = (state_q == RUN) && run_s_q;
  assign tk_if.clr = load_p;

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_s_q)     state_d = RUN;
        else if (step_p) state_d = STEP;
      end
      RUN: begin
        if (!run_s_q) state_d = IDLE;
        else          advance = tk_if.tick;
      end
      STEP: begin
        state_d = IDLE;
        advance = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load_p) begin
      bin_d = load_val;
    end else if (advance) begin
      if (dir_s_q) begin
        bin_d  = bin_q - ONE;
        wrap_d = (bin_q == '0);
      end else begin
        bin_d  = bin_q + ONE;
        wrap_d = (bin_q == MAXV);
      end
    end
    gray_d = WIDTH'(bin2gray(32'(bin_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bin_o   = bin_q;
  assign gray_o  = gray_q;
  assign wrap_o  = wrap_q;
  assign state_o = state_q;

`ifdef GRAY_SEQ_CHECK_EN
  // Decode the presented Gray value and compare it with the binary value it
  // was produced alongside, one cycle later.
  logic [WIDTH-1:0] dec_q, dec_d, bin_dly_q;
  logic             err_q, err_d;

  always_comb begin
    dec_d = WIDTH'(gray2bin(32'(gray_o)));
    err_d = err_q | (dec_q != bin_dly_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q     <= '0;
      bin_dly_q <= '0;
      err_q     <= 1'b0;
    end else begin
      dec_q     <= dec_d;
      bin_dly_q <= bin_o;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
